// File: rtl/conv_mem_host.sv
// -----------------------------------------------------------------------------
// conv_mem_host
//
// Host-side memory responder for the CONV accelerator. It takes a 64x64 image
// from a load stream, then serves the engine's image reads and its layer-bank
// reads and writes. When the engine drops busy, it streams one selected result
// bank out and pulses done. It owns the image and all five layer banks.
//
// Optional feature macro: CONV_HOST_CHECK_EN
//   defined   : err is a sticky protocol-error flag (cleared only by reset)
//   undefined : err is tied to 0 and no checker logic is built
//
// Ports
//   clk, reset                         clock, synchronous active-high reset
//   ld_valid, ld_data, ld_ready        image load stream, raster order
//   ready                              image loaded, engine may start
//   busy                               engine running
//   iaddr, idata                       image read port (asynchronous)
//   cwr, caddr_wr, cdata_wr            layer write port
//   crd, caddr_rd, cdata_rd            layer read port (asynchronous)
//   csel                               bank select: 1/2 L0, 3/4 L1, 5 L2
//   dump_sel                           bank to stream, latched when busy falls
//   dump_valid/ready/addr/data/last    result stream
//   done                               one-cycle pulse at the end of the dump
//   err                                sticky protocol error
// -----------------------------------------------------------------------------
module conv_mem_host #(
   parameter int DW = 20,
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_valid,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ready,
   output logic          ready,
   input  logic          busy,
   input  logic [AW-1:0] iaddr,
   output logic [DW-1:0] idata,
   input  logic          cwr,
   input  logic [AW-1:0] caddr_wr,
   input  logic [DW-1:0] cdata_wr,
   input  logic          crd,
   input  logic [AW-1:0] caddr_rd,
   output logic [DW-1:0] cdata_rd,
   input  logic [2:0]    csel,
   input  logic [2:0]    dump_sel,
   output logic          dump_valid,
   input  logic          dump_ready,
   output logic [AW-1:0] dump_addr,
   output logic [DW-1:0] dump_data,
   output logic          dump_last,
   output logic          done,
   output logic          err
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_RUN  = 3'd3;
   localparam logic [2:0] S_DUMP = 3'd4;

   // L1 banks hold a quarter of the image size, the L2 bank half of it.
   localparam int L1_AW = AW - 2;
   localparam int L2_AW = AW - 1;

   // ---------------------------------------------------------------------------
   // Storage
   // NOTE: the memories have no reset; contents survive reset and later runs,
   // and leaving them out of the reset net lets them map onto RAM.
   // ---------------------------------------------------------------------------
   logic [DW-1:0] r_image [0:(1<<AW)-1];
   logic [DW-1:0] r_l0k0  [0:(1<<AW)-1];
   logic [DW-1:0] r_l0k1  [0:(1<<AW)-1];
   logic [DW-1:0] r_l1k0  [0:(1<<L1_AW)-1];
   logic [DW-1:0] r_l1k1  [0:(1<<L1_AW)-1];
   logic [DW-1:0] r_l2    [0:(1<<L2_AW)-1];

   logic [2:0]    r_state;
   logic [AW-1:0] r_lcnt;
   logic          r_ld_ready;
   logic          r_ready;
   logic [2:0]    r_dump_sel;
   logic          r_dump_valid;
   logic [AW-1:0] r_dump_addr;
   logic [DW-1:0] r_dump_data;
   logic          r_dump_last;
   logic          r_done;

   logic [2:0]    w_next_state;
   logic          w_ld_fire;
   logic          w_wr_en;
   logic          w_dump_fire;
   logic          w_dump_sel_ok;
   logic [AW-1:0] w_dump_last_addr;
   logic [AW-1:0] w_dump_rd_addr;
   logic [DW-1:0] w_dump_word;

   // Shared bank read: L1/L2 banks take only their low address bits; selects
   // outside 1..5 read as zero.
   function automatic logic [DW-1:0] read_bank(input logic [2:0] sel,
                                               input logic [AW-1:0] addr);
      case (sel)
         3'd1:    return r_l0k0[addr];
         3'd2:    return r_l0k1[addr];
         3'd3:    return r_l1k0[addr[L1_AW-1:0]];
         3'd4:    return r_l1k1[addr[L1_AW-1:0]];
         3'd5:    return r_l2[addr[L2_AW-1:0]];
         default: return '0;
      endcase
   endfunction

   assign w_ld_fire   = ld_valid & r_ld_ready;
   assign w_wr_en     = cwr & ((r_state == S_WAIT) | (r_state == S_RUN));
   assign w_dump_fire = r_dump_valid & dump_ready;

   // ---------------------------------------------------------------------------
   // Dump bank geometry and prefetch address. The first beat reads address 0;
   // each accepted beat loads the word at the following address.
   // ---------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_dump_sel_ok    = 1'b1;
      w_dump_last_addr = '0;
      case (r_dump_sel)
         3'd1, 3'd2: w_dump_last_addr = AW'((1 << AW) - 1);
         3'd3, 3'd4: w_dump_last_addr = AW'((1 << L1_AW) - 1);
         3'd5:       w_dump_last_addr = AW'((1 << L2_AW) - 1);
         default:    w_dump_sel_ok    = 1'b0;
      endcase
   end

   assign w_dump_rd_addr = r_dump_valid ? (r_dump_addr + 1'b1) : '0;
   assign w_dump_word    = read_bank(r_dump_sel, w_dump_rd_addr);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_ld_fire) w_next_state = S_LOAD;
         S_LOAD: if (w_ld_fire && (r_lcnt == '1)) w_next_state = S_WAIT;
         S_WAIT: if (busy) w_next_state = S_RUN;
         S_RUN:  if (!busy) w_next_state = S_DUMP;
         S_DUMP: begin
            // r_dump_valid is low only in the first DUMP cycle.
            if (!r_dump_valid) begin
               if (!w_dump_sel_ok) w_next_state = S_IDLE;
            end else if (w_dump_fire && r_dump_last) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Control registers
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_lcnt       <= '0;
         r_ld_ready   <= 1'b0;
         r_ready      <= 1'b0;
         r_dump_sel   <= '0;
         r_dump_valid <= 1'b0;
         r_dump_addr  <= '0;
         r_dump_data  <= '0;
         r_dump_last  <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         // ld_ready and ready are registered decodes of the next state.
         r_ld_ready <= (w_next_state == S_IDLE) | (w_next_state == S_LOAD);
         r_ready    <= (w_next_state == S_WAIT);
         r_done     <= 1'b0;

         if (w_ld_fire) begin
            // lcnt wraps to 0 on the final beat, ready for the next image.
            r_lcnt <= (r_state == S_IDLE) ? AW'(1) : r_lcnt + 1'b1;
         end

         if ((r_state == S_RUN) && !busy) r_dump_sel <= dump_sel;

         if (r_state == S_DUMP) begin
            if (!r_dump_valid) begin
               if (!w_dump_sel_ok) begin
                  r_done <= 1'b1;
               end else begin
                  r_dump_valid <= 1'b1;
                  r_dump_addr  <= '0;
                  r_dump_data  <= w_dump_word;
                  r_dump_last  <= (w_dump_last_addr == '0);
               end
            end else if (w_dump_fire) begin
               if (r_dump_last) begin
                  r_dump_valid <= 1'b0;
                  r_dump_last  <= 1'b0;
                  r_done       <= 1'b1;
               end else begin
                  r_dump_addr <= w_dump_rd_addr;
                  r_dump_data <= w_dump_word;
                  r_dump_last <= (w_dump_rd_addr == w_dump_last_addr);
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Memory writes (blocked while reset is high so an in-flight beat is not
   // captured on the reset edge)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset && w_ld_fire) begin
         r_image[(r_state == S_IDLE) ? '0 : r_lcnt] <= ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_wr_en) begin
         case (csel)
            3'd1:    r_l0k0[caddr_wr]              <= cdata_wr;
            3'd2:    r_l0k1[caddr_wr]              <= cdata_wr;
            3'd3:    r_l1k0[caddr_wr[L1_AW-1:0]]   <= cdata_wr;
            3'd4:    r_l1k1[caddr_wr[L1_AW-1:0]]   <= cdata_wr;
            3'd5:    r_l2[caddr_wr[L2_AW-1:0]]     <= cdata_wr;
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Asynchronous read ports. A same-cycle write to the read address returns
   // the old word because the write lands only on the next edge.
   // ---------------------------------------------------------------------------
   assign idata    = r_image[iaddr];
   assign cdata_rd = crd ? read_bank(csel, caddr_rd) : '0;

   assign ld_ready   = r_ld_ready;
   assign ready      = r_ready;
   assign dump_valid = r_dump_valid;
   assign dump_addr  = r_dump_addr;
   assign dump_data  = r_dump_data;
   assign dump_last  = r_dump_last;
   assign done       = r_done;

   // ---------------------------------------------------------------------------
   // Protocol checker
   // ---------------------------------------------------------------------------
`ifdef CONV_HOST_CHECK_EN
   logic r_err;
   logic w_sel_bad;
   logic w_l1_sel;
   logic w_l2_sel;
   logic w_range_bad;
   logic w_err_evt;

   assign w_sel_bad = (csel == 3'd0) | (csel == 3'd6) | (csel == 3'd7);
   assign w_l1_sel  = (csel == 3'd3) | (csel == 3'd4);
   assign w_l2_sel  = (csel == 3'd5);

   assign w_range_bad =
      (w_l1_sel & cwr & (caddr_wr[AW-1:L1_AW] != '0)) |
      (w_l1_sel & crd & (caddr_rd[AW-1:L1_AW] != '0)) |
      (w_l2_sel & cwr & caddr_wr[AW-1]) |
      (w_l2_sel & crd & caddr_rd[AW-1]);

   assign w_err_evt =
      (cwr & crd) |
      ((cwr | crd) & w_sel_bad) |
      (cwr & (r_state != S_WAIT) & (r_state != S_RUN)) |
      w_range_bad |
      (busy & ((r_state == S_IDLE) | (r_state == S_LOAD)));

   always_ff @(posedge clk) begin
      if (reset)          r_err <= 1'b0;
      else if (w_err_evt) r_err <= 1'b1;
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule
